// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and glyph table for the multiplexed 7-segment scan controller.
// Segment bit order: bit0=a, bit1=b, ... bit6=g, bit7=dp, all active-high.
package seg_scan_ctrl_pkg;

  localparam int              SEG_DP     = 7;
  localparam logic [7:0]      SEG_BLANK  = 8'h00;
  localparam int              MAX_DIGITS = 8;
  // Common-cathode digit enables are active-low, so all ones turns every digit off.
  localparam logic [MAX_DIGITS-1:0] COM_OFF = '1;

  // Nibbles above 9 have no glyph and decode to dark segments.
  function automatic logic [6:0] bcd_glyph(input logic [3:0] i_bcd);
    case (i_bcd)
      4'd0:    bcd_glyph = 7'h3F;
      4'd1:    bcd_glyph = 7'h06;
      4'd2:    bcd_glyph = 7'h5B;
      4'd3:    bcd_glyph = 7'h4F;
      4'd4:    bcd_glyph = 7'h66;
      4'd5:    bcd_glyph = 7'h6D;
      4'd6:    bcd_glyph = 7'h7D;
      4'd7:    bcd_glyph = 7'h07;
      4'd8:    bcd_glyph = 7'h7F;
      4'd9:    bcd_glyph = 7'h67;
      default: bcd_glyph = 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_bcd_seg.sv
// Combinational BCD to 7-segment decoder with a pass-through decimal point.
module bcd_seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  assign o_seg = {i_dp, bcd_glyph(i_bcd)};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode multi-digit 7-segment display,
// with a double-buffered display value, leading-zero blanking and anti-ghosting.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank_lz,
  output logic [7:0]              seg_data,
  output logic [NUM_DIGITS-1:0]   digit_com,
  output logic                    update_pending
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [NUM_DIGITS-1:0] L_COM_OFF  = COM_OFF[NUM_DIGITS-1:0];
  localparam logic [PRE_W-1:0]      L_PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      L_IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]      r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_idx_chg;
  logic [VAL_W-1:0]      r_disp;
  logic [VAL_W-1:0]      r_shadow;
  logic                  r_pending;
  logic [7:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_com;

  logic                  w_tick;
  logic                  w_fb;
  logic [3:0]            w_nibble;
  logic                  w_dp;
  logic                  w_blank;
  logic [NUM_DIGITS-1:0] w_lead_zero;
  logic                  w_run;
  logic [7:0]            w_dec;
  logic [7:0]            w_seg_next;
  logic [NUM_DIGITS-1:0] w_com_next;

  assign w_tick = (r_presc == L_PRE_LAST);
  assign w_fb   = w_tick && (r_idx == L_IDX_LAST);

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc   <= '0;
      r_idx     <= '0;
      r_idx_chg <= 1'b0;
    end else begin
      r_presc   <= w_tick ? '0 : r_presc + PRE_W'(1);
      r_idx_chg <= w_tick;
      if (w_tick) r_idx <= (r_idx == L_IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end
  end

  // A load coinciding with the frame boundary bypasses the shadow entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp    <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else if (load && w_fb) begin
      r_disp    <= value_in;
      r_pending <= 1'b0;
    end else if (load) begin
      r_shadow  <= value_in;
      r_pending <= 1'b1;
    end else if (w_fb && r_pending) begin
      r_disp    <= r_shadow;
      r_pending <= 1'b0;
    end
  end

  // NOTE: every always_comb output gets a default before any conditional
  // assignment; otherwise an uncovered path would infer a latch.
  always_comb begin
    w_lead_zero = '0;
    w_run       = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_run          = w_run && (r_disp[4*k +: 4] == 4'h0);
      w_lead_zero[k] = w_run;
    end
  end

  always_comb begin
    w_nibble = 4'h0;
    w_dp     = 1'b0;
    w_blank  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nibble = r_disp[4*k +: 4];
        w_dp     = dp_mask[k];
        w_blank  = blank_lz && w_lead_zero[k];
      end
    end
  end

  bcd_seg u_bcd_seg (
    .i_bcd (w_nibble),
    .i_dp  (w_dp),
    .o_seg (w_dec)
  );

  // The decimal point survives blanking; only the glyph segments are cleared.
  assign w_seg_next = {w_dec[SEG_DP], w_blank ? 7'h00 : w_dec[SEG_DP-1:0]};
  assign w_com_next = ~(NUM_DIGITS'(1) << r_idx);

  // The cycle right after an index change is forced dark to avoid ghosting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= SEG_BLANK;
      r_com <= L_COM_OFF;
    end else if (r_idx_chg) begin
      r_seg <= SEG_BLANK;
      r_com <= L_COM_OFF;
    end else begin
      r_seg <= w_seg_next;
      r_com <= w_com_next;
    end
  end

  assign seg_data       = r_seg;
  assign digit_com      = r_com;
  assign update_pending = r_pending;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=4.
// After reset release, edge n shows digit d of frame f lit at n = 16f+4d+2..+4, dark at 16f+4d+1.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic [7:0]  seg_data;
  logic [3:0]  digit_com;
  logic        update_pending;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  seg_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .load           (load),
    .value_in       (value_in),
    .dp_mask        (dp_mask),
    .blank_lz       (blank_lz),
    .seg_data       (seg_data),
    .digit_com      (digit_com),
    .update_pending (update_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int k);
    while (cyc < k) step();
  endtask

  task automatic do_load(input logic [15:0] val);
    load     = 1'b1;
    value_in = val;
    step();
    load     = 1'b0;
  endtask

  task automatic chk_slot(input int f, input int d, input logic [7:0] exp, input string tag);
    logic [3:0] e_com;
    goto(16*f + 4*d + 3);
    e_com = ~(4'b0001 << d);
    chk({tag, " com"}, {4'h0, digit_com}, {4'h0, e_com});
    chk({tag, " seg"}, seg_data, exp);
  endtask

  task automatic chk_off(input int f, input int d, input string tag);
    goto(16*f + 4*d + 1);
    chk({tag, " com"}, {4'h0, digit_com}, 8'h0F);
    chk({tag, " seg"}, seg_data, 8'h00);
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    value_in = 16'h0000;
    dp_mask  = 4'b0000;
    blank_lz = 1'b0;

    // 1. reset then idle
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst com", {4'h0, digit_com}, 8'h0F);
    chk("rst seg", seg_data, 8'h00);
    chk("rst pend", {7'h0, update_pending}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    step();
    chk("first d0 com", {4'h0, digit_com}, 8'h0E);
    chk("first d0 seg", seg_data, 8'h3F);
    chk_slot(0, 0, 8'h3F, "idle d0");
    chk_off(0, 1, "ghost 0->1");
    chk_slot(0, 1, 8'h3F, "idle d1");
    chk_off(0, 2, "ghost 1->2");
    chk_slot(0, 2, 8'h3F, "idle d2");
    chk_off(0, 3, "ghost 2->3");
    chk_slot(0, 3, 8'h3F, "idle d3");
    chk_off(1, 0, "ghost 3->0");

    // 2. mid-frame load waits for the frame boundary
    goto(19);
    do_load(16'h1234);
    chk("load pend", {7'h0, update_pending}, 8'h01);
    chk_slot(1, 1, 8'h3F, "old d1");
    chk_slot(1, 3, 8'h3F, "old d3");
    chk("pend pre-fb", {7'h0, update_pending}, 8'h01);
    goto(32);
    chk("pend post-fb", {7'h0, update_pending}, 8'h00);
    chk_slot(2, 0, 8'h66, "1234 d0");
    chk_slot(2, 1, 8'h4F, "1234 d1");
    chk_slot(2, 2, 8'h5B, "1234 d2");
    chk_slot(2, 3, 8'h06, "1234 d3");

    // 3. leading-zero blanking with a live decimal point
    goto(50);
    blank_lz = 1'b1;
    dp_mask  = 4'b0100;
    do_load(16'h0070);
    chk_slot(3, 2, 8'hDB, "live dp d2");
    chk("pend 0070", {7'h0, update_pending}, 8'h01);
    chk_slot(4, 0, 8'h3F, "0070 d0");
    chk_slot(4, 1, 8'h07, "0070 d1");
    chk_slot(4, 2, 8'h80, "0070 d2");
    chk_slot(4, 3, 8'h00, "0070 d3");
    dp_mask = 4'b0000;
    goto(81);
    do_load(16'h0000);
    chk_slot(6, 0, 8'h3F, "zero d0");
    chk_slot(6, 1, 8'h00, "zero d1");
    chk_slot(6, 2, 8'h00, "zero d2");
    chk_slot(6, 3, 8'h00, "zero d3");

    // 4. last load wins, then load exactly on the frame boundary
    goto(113);
    do_load(16'h1111);
    goto(116);
    do_load(16'h2222);
    chk("pend 2222", {7'h0, update_pending}, 8'h01);
    goto(128);
    chk("pend fb 2222", {7'h0, update_pending}, 8'h00);
    chk_slot(8, 0, 8'h5B, "2222 d0");
    chk_slot(8, 2, 8'h5B, "2222 d2");
    chk_slot(8, 3, 8'h5B, "2222 d3");
    do_load(16'h9999);
    chk("pend bypass", {7'h0, update_pending}, 8'h00);
    chk_slot(9, 0, 8'h67, "9999 d0");
    chk_slot(9, 1, 8'h67, "9999 d1");
    chk_slot(9, 2, 8'h67, "9999 d2");
    chk_slot(9, 3, 8'h67, "9999 d3");

    // 5. invalid nibbles decode dark and count as non-zero
    goto(161);
    do_load(16'h00A5);
    chk_slot(11, 0, 8'h6D, "00A5 d0");
    chk_slot(11, 1, 8'h00, "00A5 d1");
    chk_slot(11, 2, 8'h00, "00A5 d2");
    chk_slot(11, 3, 8'h00, "00A5 d3");
    goto(193);
    do_load(16'h0A05);
    chk_slot(13, 0, 8'h6D, "0A05 d0");
    chk_slot(13, 1, 8'h3F, "0A05 d1");
    chk_slot(13, 2, 8'h00, "0A05 d2");
    chk_slot(13, 3, 8'h00, "0A05 d3");

    // 6. asynchronous reset while digit 2 is lit with a pending load
    goto(225);
    do_load(16'h1234);
    goto(234);
    chk("pre-rst com", {4'h0, digit_com}, 8'h0B);
    chk("pre-rst pend", {7'h0, update_pending}, 8'h01);
    #3;
    rst = 1'b1;
    #1;
    chk("async com", {4'h0, digit_com}, 8'h0F);
    chk("async seg", seg_data, 8'h00);
    chk("async pend", {7'h0, update_pending}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    step();
    chk("restart com", {4'h0, digit_com}, 8'h0E);
    chk("restart seg", seg_data, 8'h3F);
    chk("restart pend", {7'h0, update_pending}, 8'h00);
    chk_off(0, 1, "restart ghost");
    chk_slot(0, 1, 8'h00, "restart d1");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
